// File: rtl/dec_scan.sv
// dec_scan: binary-to-one-hot decoder with registered output
// and an autonomous scan mode that walks the hot bit with a dwell.
module dec_scan #(
    parameter int SEL_W   = 2,
    parameter int DWELL   = 4,
    parameter int DIS_VAL = 1,
    localparam int OUT_W  = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    output logic [OUT_W-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [OUT_W-1:0] DIS_Y =
        (DIS_VAL != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   idx_inc;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign idx_inc = idx_q + SEL_W'(1);

    // State and output registers; reset forces the disabled pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= DIS_Y;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mode selection from en/mode, then next output for that mode.
    always_comb begin
        state_d = IDLE;
        y_d     = y_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        cnt_d   = '0;
        if (en) begin
            state_d = mode ? SCAN : DECODE;
        end
        unique case (state_d)
            IDLE: begin
                y_d = DIS_Y;
            end
            DECODE: begin
                y_d   = ONE << sel;
                idx_d = sel;
            end
            SCAN: begin
                // Entry or load restarts at sel and beats any advance.
                if (state_q != SCAN || load) begin
                    y_d   = ONE << sel;
                    idx_d = sel;
                end else if (cnt_q == CNT_LAST) begin
                    y_d    = ONE << idx_inc;
                    idx_d  = idx_inc;
                    wrap_d = (idx_q == {SEL_W{1'b1}});
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                y_d = DIS_Y;
            end
        endcase
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
